// File: rtl/branch_rs.sv
// branch_rs: reservation station for conditional branches.
// Compacting age-ordered queue with CDB wakeup and oldest-first issue.
module branch_rs #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [3:0]  disp_opcode,
  input  logic [3:0]  disp_rob_index,
  input  logic        disp_t_ready,
  input  logic [3:0]  disp_t_tag,
  input  logic [15:0] disp_t_value,
  input  logic        disp_a_ready,
  input  logic [3:0]  disp_a_tag,
  input  logic [15:0] disp_a_value,
  input  logic        cdb_valid,
  input  logic [3:0]  cdb_tag,
  input  logic [15:0] cdb_value,
  output logic        issue_valid,
  output logic [3:0]  issue_opcode,
  output logic [3:0]  issue_rob_index,
  output logic [15:0] issue_vt,
  output logic [15:0] issue_va
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rob;
    logic        t_rdy;
    logic [3:0]  t_tag;
    logic [15:0] t_val;
    logic        a_rdy;
    logic [3:0]  a_tag;
    logic [15:0] a_val;
  } ent_t;

  ent_t ent_q [DEPTH];
  ent_t ent_d [DEPTH];
  ent_t ent_x [DEPTH+1];
  ent_t new_e;
  ent_t sel_e;

  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr_idx;
  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] shift;
  logic             issued;
  logic             accept;
  logic             t_hit;
  logic             a_hit;

  assign disp_ready = (count_q != CW'(DEPTH));

  // Oldest eligible entry; shift marks the selected slot and all above it.
  always_comb begin
    elig   = '0;
    sel_oh = '0;
    shift  = '0;
    issued = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = (CW'(i) < count_q) &&
                ent_q[i].t_rdy && ent_q[i].a_rdy;
      if (elig[i] && !issued) begin
        sel_oh[i] = 1'b1;
        issued    = 1'b1;
      end
      shift[i] = issued;
    end
  end

  // Issue mux from registered state only; zero when nothing is selected.
  always_comb begin
    sel_e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) sel_e = sel_e | ent_q[i];
    end
  end

  assign issue_valid     = issued;
  assign issue_opcode    = sel_e.op;
  assign issue_rob_index = sel_e.rob;
  assign issue_vt        = sel_e.t_val;
  assign issue_va        = sel_e.a_val;

  // Incoming entry, with same-cycle CDB bypass for pending operands.
  always_comb begin
    t_hit = !disp_t_ready && cdb_valid &&
            (cdb_tag == disp_t_tag);
    a_hit = !disp_a_ready && cdb_valid &&
            (cdb_tag == disp_a_tag);
    new_e.op    = disp_opcode;
    new_e.rob   = disp_rob_index;
    new_e.t_rdy = disp_t_ready || t_hit;
    new_e.t_tag = disp_t_tag;
    new_e.t_val = t_hit ? cdb_value : disp_t_value;
    new_e.a_rdy = disp_a_ready || a_hit;
    new_e.a_tag = disp_a_tag;
    new_e.a_val = a_hit ? cdb_value : disp_a_value;
  end

  // Next state: compact out the issued slot, capture CDB, append dispatch.
  always_comb begin
    accept  = disp_valid && disp_ready && !flush;
    wr_idx  = count_q - CW'(issued);
    count_d = wr_idx + CW'(accept);
    for (int i = 0; i < DEPTH; i++) ent_x[i] = ent_q[i];
    ent_x[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = shift[i] ? ent_x[i+1] : ent_x[i];
      if (cdb_valid && !ent_d[i].t_rdy &&
          ent_d[i].t_tag == cdb_tag) begin
        ent_d[i].t_rdy = 1'b1;
        ent_d[i].t_val = cdb_value;
      end
      if (cdb_valid && !ent_d[i].a_rdy &&
          ent_d[i].a_tag == cdb_tag) begin
        ent_d[i].a_rdy = 1'b1;
        ent_d[i].a_val = cdb_value;
      end
      if (accept && CW'(i) == wr_idx) ent_d[i] = new_e;
    end
    if (flush) count_d = '0;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// tb_branch_rs: directed vector bench for branch_rs.
// One table row per cycle: inputs plus outputs visible that cycle.
module tb_branch_rs;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_opcode;
  logic [3:0]  disp_rob_index;
  logic        disp_t_ready;
  logic [3:0]  disp_t_tag;
  logic [15:0] disp_t_value;
  logic        disp_a_ready;
  logic [3:0]  disp_a_tag;
  logic [15:0] disp_a_value;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic        issue_valid;
  logic [3:0]  issue_opcode;
  logic [3:0]  issue_rob_index;
  logic [15:0] issue_vt;
  logic [15:0] issue_va;

  branch_rs #(.DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .disp_valid(disp_valid),
    .disp_ready(disp_ready),
    .disp_opcode(disp_opcode),
    .disp_rob_index(disp_rob_index),
    .disp_t_ready(disp_t_ready),
    .disp_t_tag(disp_t_tag),
    .disp_t_value(disp_t_value),
    .disp_a_ready(disp_a_ready),
    .disp_a_tag(disp_a_tag),
    .disp_a_value(disp_a_value),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_value(cdb_value),
    .issue_valid(issue_valid),
    .issue_opcode(issue_opcode),
    .issue_rob_index(issue_rob_index),
    .issue_vt(issue_vt),
    .issue_va(issue_va)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        dv;
    logic [3:0]  op;
    logic [3:0]  rob;
    logic        tr;
    logic [3:0]  tt;
    logic [15:0] tv;
    logic        ar;
    logic [3:0]  at;
    logic [15:0] av;
    logic        cv;
    logic [3:0]  ct;
    logic [15:0] cval;
    logic        edr;
    logic        eiv;
    logic [3:0]  eop;
    logic [3:0]  erob;
    logic [15:0] evt;
    logic [15:0] eva;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;
  int   checks;
  int   failures;
  int   row;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h",
               name, row, act, exp);
    end
  endtask

  task automatic nw();
    cur = '{default: 0};
    cur.edr = 1'b1;
  endtask

  task automatic dsp(logic [3:0] op, logic [3:0] rob,
                     logic tr, logic [3:0] tt, logic [15:0] tv,
                     logic ar, logic [3:0] at, logic [15:0] av);
    cur.dv  = 1'b1;
    cur.op  = op;
    cur.rob = rob;
    cur.tr  = tr;
    cur.tt  = tt;
    cur.tv  = tv;
    cur.ar  = ar;
    cur.at  = at;
    cur.av  = av;
  endtask

  task automatic cdb(logic [3:0] tag, logic [15:0] val);
    cur.cv   = 1'b1;
    cur.ct   = tag;
    cur.cval = val;
  endtask

  task automatic ex(logic dr, logic iv, logic [3:0] op,
                    logic [3:0] rob, logic [15:0] vt,
                    logic [15:0] va);
    cur.edr  = dr;
    cur.eiv  = iv;
    cur.eop  = op;
    cur.erob = rob;
    cur.evt  = vt;
    cur.eva  = va;
  endtask

  task automatic put();
    tbl.push_back(cur);
  endtask

  task automatic drive(vec_t v);
    reset          = v.rst;
    flush          = v.fl;
    disp_valid     = v.dv;
    disp_opcode    = v.op;
    disp_rob_index = v.rob;
    disp_t_ready   = v.tr;
    disp_t_tag     = v.tt;
    disp_t_value   = v.tv;
    disp_a_ready   = v.ar;
    disp_a_tag     = v.at;
    disp_a_value   = v.av;
    cdb_valid      = v.cv;
    cdb_tag        = v.ct;
    cdb_value      = v.cval;
  endtask

  task automatic build();
    // ready dispatch
    nw(); dsp(4'h8, 4'd3, 1, 0, 16'h0040, 1, 0, 16'h0000); put();
    nw(); ex(1, 1, 4'h8, 4'd3, 16'h0040, 16'h0000); put();
    nw(); put();
    // CDB wakeup and ordering
    nw(); dsp(4'h9, 4'd5, 1, 0, 16'h1111, 0, 4'd7, 16'h0); put();
    nw(); dsp(4'hA, 4'd6, 1, 0, 16'h2222, 1, 0, 16'h3333); put();
    nw(); ex(1, 1, 4'hA, 4'd6, 16'h2222, 16'h3333); put();
    nw(); cdb(4'd7, 16'h8001); put();
    nw(); ex(1, 1, 4'h9, 4'd5, 16'h1111, 16'h8001); put();
    nw(); put();
    // dispatch bypass
    nw(); dsp(4'hB, 4'd2, 1, 0, 16'h0ABC, 0, 4'd2, 16'h0);
    cdb(4'd2, 16'h0001); put();
    nw(); ex(1, 1, 4'hB, 4'd2, 16'h0ABC, 16'h0001); put();
    nw(); put();
    // full
    for (int i = 0; i < 4; i++) begin
      nw();
      dsp(4'h8, 4'(8 + i), 1, 0, 16'(16'h0100 + i),
          0, 4'd9, 16'h0);
      put();
    end
    nw(); dsp(4'hC, 4'd12, 1, 0, 16'h0C0C, 1, 0, 16'hC0C0);
    cdb(4'd9, 16'h0909); ex(0, 0, 0, 0, 0, 0); put();
    nw(); dsp(4'hC, 4'd12, 1, 0, 16'h0C0C, 1, 0, 16'hC0C0);
    ex(0, 1, 4'h8, 4'd8, 16'h0100, 16'h0909); put();
    nw(); dsp(4'hC, 4'd12, 1, 0, 16'h0C0C, 1, 0, 16'hC0C0);
    ex(1, 1, 4'h8, 4'd9, 16'h0101, 16'h0909); put();
    nw(); ex(1, 1, 4'h8, 4'd10, 16'h0102, 16'h0909); put();
    nw(); ex(1, 1, 4'h8, 4'd11, 16'h0103, 16'h0909); put();
    nw(); ex(1, 1, 4'hC, 4'd12, 16'h0C0C, 16'hC0C0); put();
    nw(); put();
    // flush
    for (int i = 1; i <= 3; i++) begin
      nw(); dsp(4'h8, 4'(i), 0, 4'd4, 16'h0, 1, 0, 16'h0005);
      put();
    end
    nw(); cur.fl = 1'b1;
    dsp(4'h8, 4'd4, 1, 0, 16'h4444, 1, 0, 16'h4545); put();
    nw(); put();
    nw(); cdb(4'd4, 16'h7777); put();
    nw(); put();
    // reset mid-operation
    nw(); dsp(4'h8, 4'd7, 1, 0, 16'h0001, 1, 0, 16'h0002); put();
    nw(); cur.rst = 1'b1;
    dsp(4'h8, 4'd9, 1, 0, 16'h0003, 1, 0, 16'h0004);
    ex(1, 1, 4'h8, 4'd7, 16'h0001, 16'h0002); put();
    nw(); put();
    nw(); put();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    row      = -1;
    build();
    nw();
    drive(cur);
    reset = 1'b1;
    disp_valid = 1'b1;
    disp_t_ready = 1'b1;
    disp_a_ready = 1'b1;
    disp_rob_index = 4'd1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    end
    reset = 1'b0;
    disp_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("post_rst_rob", 32'(issue_rob_index), 32'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      row = i;
      drive(tbl[i]);
      #1;
      chk("disp_ready", 32'(disp_ready), 32'(tbl[i].edr));
      chk("issue_valid", 32'(issue_valid), 32'(tbl[i].eiv));
      chk("issue_opcode", 32'(issue_opcode), 32'(tbl[i].eop));
      chk("issue_rob", 32'(issue_rob_index), 32'(tbl[i].erob));
      chk("issue_vt", 32'(issue_vt), 32'(tbl[i].evt));
      chk("issue_va", 32'(issue_va), 32'(tbl[i].eva));
      @(posedge clk);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_rs.md
# branch_rs

Reservation station for conditional-branch instructions (opcodes 1000–1011). It sits between dispatch and the branch unit. It holds up to `DEPTH` branches, captures missing operands from the common data bus (CDB), and each cycle issues the oldest operand-complete entry to the branch unit. The branch unit never stalls, so an issued entry leaves the station unconditionally.

## Interface
Parameters:
- `DEPTH`, 4: number of entries (2..8).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all entries.
- `flush`  in  1  mispredict/exception flush; discards all entries.
- `disp_valid`  in  1  dispatch request.
- `disp_ready`  out  1  station can accept a dispatch this cycle.
- `disp_opcode`  in  4  branch opcode.
- `disp_rob_index`  in  4  ROB index of the branch.
- `disp_t_ready`  in  1  target operand value present.
- `disp_t_tag`  in  4  producer ROB tag of the target operand, used when not ready.
- `disp_t_value`  in  16  target operand value, used when ready.
- `disp_a_ready`, `disp_a_tag`, `disp_a_value`  in  1/4/16  same fields for the condition operand.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  4  ROB tag of the broadcast result.
- `cdb_value`  in  16  broadcast result value.
- `issue_valid`  out  1  issue to branch unit.
- `issue_opcode`  out  4  issued opcode.
- `issue_rob_index`  out  4  issued ROB index.
- `issue_vt`  out  16  issued target value.
- `issue_va`  out  16  issued condition value.

## Operation
- Storage is a compacting age-ordered queue. Slot 0 is the oldest; valid slots are contiguous from 0. `count` lies in 0..DEPTH.
- Per-entry fields:
  - opcode and rob_index;
  - for each of the t and a operands: a ready bit, a tag, and a value.
- `disp_ready = (count != DEPTH)`. This is a registered-state function only; an issue in the same cycle does not credit a slot.
- Dispatch is accepted when `disp_valid && disp_ready && !flush`. The new entry is written at slot `count - issued`, where `issued` is 1 if an issue happens this cycle and 0 otherwise.
- CDB capture for held entries:
  - Applies to every valid held entry whose operand is not ready and whose tag equals `cdb_tag`, when `cdb_valid` is high.
  - Effect: value ← `cdb_value`, ready ← 1.
- CDB bypass on dispatch: if a dispatching operand is not ready and `cdb_valid && cdb_tag == disp_x_tag`, the entry is written with ready = 1 and value = `cdb_value`.
- Issue selection:
  - An entry is eligible when it is valid and both of its registered ready bits are set.
  - The lowest-index (oldest) eligible entry is selected.
  - `issue_*` are combinational from registered state only; there are no paths from `disp_*` or `cdb_*` to the outputs.
  - An opcode outside 1000–1011 is issued unchanged; the branch unit resolves it as not-taken.
- On the issuing edge, the selected entry is removed and all younger entries shift down by one slot. CDB captures apply to the shifted entries in the same edge.
- While `issue_valid = 0`, the `issue_*` data outputs hold 0.
- `flush` or `reset`: all entries are invalidated and `count` ← 0.
  - `reset` has priority over `flush`.
  - Both have priority over dispatch, capture and issue.
  - The issue visible during a flush cycle is still presented combinationally. The downstream unit is responsible for ignoring it under flush.

## Timing
- Reset values: `count` = 0, so `disp_ready` = 1, `issue_valid` = 0, and all `issue_*` data = 0.
- Dispatch in cycle N with both operands ready → `issue_valid` in cycle N+1, provided no older entry is eligible.
- CDB broadcast in cycle N that completes an entry → entry is eligible in cycle N+1.
  - A completing CDB broadcast in the dispatch cycle counts as ready on dispatch, so the entry issues in N+1.
- Throughput is at most one issue per cycle and one dispatch per cycle.
- Full case: when `count == DEPTH`, a dispatch is refused even if an issue occurs in the same cycle. `disp_ready` rises in the cycle after the issue.
- Simultaneous CDB capture and dispatch of a different tag: both happen, with no interaction.
- `reset` asserted mid-operation: all state is cleared at that edge. The next cycle is identical to the post-reset state.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `disp_valid` = 1. Require:
  - `issue_valid` = 0 throughout;
  - no entry captured;
  - `disp_ready` = 1 after reset.
- **Ready dispatch:** dispatch opcode 1000, rob 3, t = 0x0040, a = 0x0000, both operands ready, in cycle 0. Require `issue_valid` = 1 in cycle 1 with rob 3, vt 0x0040, va 0x0000; then `issue_valid` = 0 in cycle 2.
- **CDB wakeup and ordering:**
  - Cycle 0: dispatch rob 5 with a pending on tag 7.
  - Cycle 1: dispatch rob 6 with both operands ready.
  - Require rob 6 to issue in cycle 2.
  - Cycle 3: CDB broadcasts tag 7 = 0x8001.
  - Require rob 5 to issue in cycle 4 with va = 0x8001.
- **Dispatch bypass:** dispatch with a pending on tag 2 while CDB broadcasts tag 2 = 0x0001 in the same cycle. Require issue in the next cycle with va = 0x0001.
- **Full:**
  - Fill 4 entries, each with a pending on tag 9; require `disp_ready` = 0.
  - Hold `disp_valid` high and broadcast tag 9.
  - Require issues of the entries in dispatch order on 4 consecutive cycles.
  - Require `disp_ready` = 1 from the first issue cycle + 1.
  - Require the blocked dispatch to be accepted only after `disp_ready` rises.
- **Flush:** with 3 entries held and a dispatch active, assert `flush` for 1 cycle. Require:
  - `count` = 0 next cycle;
  - `issue_valid` = 0;
  - the dispatched entry is not captured;
  - a later CDB broadcast produces no issue.
